// File: rtl/mcu_timer.sv
// mcu_timer: countdown timer with period load, run/pause, readback and one-clk expiry pulse; optional prescaler under MCU_TIMER_PRESCALE_EN
module mcu_timer #(
  parameter int AUTO_RELOAD = 1,
  parameter int PRESCALE    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_cs,
  input  logic        timer_wr,
  input  logic        timer_start,
  input  logic        timer_rd,
  input  logic [15:0] timer_datain,
  output logic [15:0] timer_value,
  output logic        timer_INT
);
  typedef enum logic [1:0] {IDLE, LOADED, RUN, DONE} state_t;
  state_t state, state_n;
  logic [15:0] reload_reg, reload_n, count, count_n;
  logic int_n, wr, run, tick;
  assign wr  = timer_cs & timer_wr;
  assign run = timer_cs & timer_start;
`ifdef MCU_TIMER_PRESCALE_EN
  logic [7:0] pre, pre_n;
  assign tick  = pre == 8'(PRESCALE - 1);
  // prescaler only advances while actively running; any write, pause or exit restarts it
  assign pre_n = (wr || state != RUN || !run || tick) ? 8'd0 : pre + 8'd1;
  // prescaler register
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= 8'd0;
    else pre <= pre_n;
`else
  localparam int unused_prescale = PRESCALE;
  assign tick = 1'b1;
`endif
  // next state: write wins over everything, including a coincident expiry
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    int_n    = 1'b0;
    if (wr) begin
      reload_n = timer_datain;
      count_n  = timer_datain;
      state_n  = LOADED;
    end else if (state == LOADED && run) begin
      state_n = RUN;
    end else if (state == RUN) begin
      if (!run) state_n = LOADED;
      else if (tick && count != 16'd1) count_n = count - 16'd1;
      else if (tick) begin
        int_n   = 1'b1;
        count_n = AUTO_RELOAD != 0 ? reload_reg : 16'd0;
        state_n = AUTO_RELOAD != 0 ? RUN : DONE;
      end
    end
  end
  // state, count, period and interrupt registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      count      <= 16'd0;
      reload_reg <= 16'd0;
      timer_INT  <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      timer_INT  <= int_n;
    end
  // readback snapshot of the pre-edge count
  always_ff @(posedge clk or posedge rst)
    if (rst) timer_value <= 16'd0;
    else if (timer_cs && timer_rd) timer_value <= count;
endmodule

// File: tb/tb_mcu_timer.sv
// tb_mcu_timer: periodic and one-shot timers driven in parallel, checked against a behavioural model
module tb_mcu_timer;
  localparam int PS = 4;
  logic clk = 0, rst;
  logic cs, wr, start, rd;
  logic [15:0] din, val0, val1;
  logic int0, int1;
  int checks = 0, errors = 0;
  logic [15:0] m_cnt[2], m_per[2], m_val[2];
  bit m_int[2], m_loaded[2], m_run[2], m_done[2];
  int m_pre[2];

  always #5 clk = ~clk;

  mcu_timer #(.AUTO_RELOAD(0), .PRESCALE(PS)) u0 (
    .clk(clk), .rst(rst), .timer_cs(cs), .timer_wr(wr), .timer_start(start),
    .timer_rd(rd), .timer_datain(din), .timer_value(val0), .timer_INT(int0));
  mcu_timer #(.AUTO_RELOAD(1), .PRESCALE(PS)) u1 (
    .clk(clk), .rst(rst), .timer_cs(cs), .timer_wr(wr), .timer_start(start),
    .timer_rd(rd), .timer_datain(din), .timer_value(val1), .timer_INT(int1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_per[i] = 0; m_val[i] = 0; m_int[i] = 0;
      m_loaded[i] = 0; m_run[i] = 0; m_done[i] = 0; m_pre[i] = 0;
    end
  endtask

  task automatic model_step();
    bit go, tick;
    go = cs & start;
    for (int i = 0; i < 2; i++) begin
      m_int[i] = 0;
      if (cs & rd) m_val[i] = m_cnt[i];
      if (cs & wr) begin
        m_per[i] = din; m_cnt[i] = din; m_loaded[i] = 1;
        m_run[i] = 0; m_done[i] = 0; m_pre[i] = 0;
      end else if (m_run[i]) begin
        if (!go) begin
          m_run[i] = 0; m_pre[i] = 0;
        end else begin
`ifdef MCU_TIMER_PRESCALE_EN
          tick = (m_pre[i] == PS - 1);
          m_pre[i] = tick ? 0 : m_pre[i] + 1;
`else
          tick = 1;
`endif
          if (tick) begin
            if (m_cnt[i] == 1) begin
              m_int[i] = 1;
              if (i == 1) m_cnt[i] = m_per[i];
              else begin m_cnt[i] = 0; m_run[i] = 0; m_done[i] = 1; end
            end else m_cnt[i] = m_cnt[i] - 16'd1;
          end
        end
      end else if (m_loaded[i] && !m_done[i] && go) m_run[i] = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    check("val_oneshot", val0, m_val[0]);
    check("int_oneshot", int0, m_int[0]);
    check("val_periodic", val1, m_val[1]);
    check("int_periodic", int1, m_int[1]);
  endtask

  task automatic drive(input logic c, input logic w, input logic s, input logic r, input logic [15:0] d);
    cs = c; wr = w; start = s; rd = r; din = d;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check("rst_val0", val0, 0);
    check("rst_int0", int0, 0);
    check("rst_val1", val1, 0);
    check("rst_int1", int1, 0);
    model_reset();
    cycle();
    rst = 0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    model_reset();
    rst = 1;
    #1;
    check("init_val", val1, 0);
    check("init_int", int1, 0);
    cycle();
    rst = 0;
    // start before any write is ignored
    drive(1, 0, 1, 1, 0);
    cycles(5);
    // periodic 3: pulses at E4, E7, E10; one-shot stops after first
    drive(1, 1, 0, 0, 3); cycle();
    drive(1, 0, 1, 1, 0); cycles(3);
    cycle();
    check("periodic_E4", int1, 1);
    check("oneshot_E4", int0, 1);
    cycles(20);
    drive(1, 1, 0, 0, 5); cycle();
    drive(1, 0, 1, 1, 0); cycles(12);
    // pause and resume
    drive(1, 1, 0, 0, 10); cycle();
    drive(1, 0, 1, 0, 0); cycles(5);
    drive(1, 0, 0, 1, 0); cycles(7);
    check("pause_val", val1, 6);
    drive(1, 0, 1, 0, 0); cycles(8);
    // write colliding with expiry
    drive(1, 1, 0, 0, 1); cycle();
    drive(1, 0, 1, 0, 0); cycle();
    drive(1, 1, 1, 0, 16'h0020); cycle();
    check("collide_int", int1, 0);
    drive(1, 0, 0, 1, 0); cycle();
    check("collide_val", val1, 16'h0020);
    // zero period wraps, then reset mid-run
    drive(1, 1, 0, 0, 0); cycle();
    drive(1, 0, 1, 1, 0); cycles(3);
    check("zero_wrap", val1, 16'hFFFF);
    cycles(4);
    do_reset();
    drive(1, 0, 1, 1, 0); cycles(10);
    // randomized traffic
    drive(1, 1, 0, 0, 4); cycle();
    for (int n = 0; n < 4000; n++) begin
      drive($urandom % 8 != 0, $urandom % 16 == 0, $urandom % 6 != 0, $urandom % 2 == 1,
            ($urandom % 5 == 0) ? 16'($urandom) : 16'($urandom_range(0, 6)));
      if ($urandom % 700 == 0) do_reset(); else cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
